// File: rtl/array_rw_arbiter_pkg.sv
// array_rw_arbiter_pkg
//   Shared definitions for the SRAM front-end controller: default geometry of
//   the 4096 x 20 masked single-port macro, write-mask segment width, the
//   controller state enum and the port-grant enum.
package array_rw_arbiter_pkg;

  localparam int ARR_ADDR_W   = 12;
  localparam int ARR_DATA_W   = 20;
  localparam int ARR_MASK_SEG = 4;
  localparam int SEG_W        = ARR_DATA_W / ARR_MASK_SEG;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } grant_t;

endpackage

// File: rtl/array_rsp_fifo.sv
// array_rsp_fifo
//   Circular response FIFO, DEPTH entries of DATA_W bits. Pointers wrap modulo
//   DEPTH, so non-power-of-two depths are supported. Storage is not reset;
//   only pointers and the occupancy count are.
// Ports:
//   clock, reset      - clock, synchronous active-high reset
//   push, push_data   - write an entry at the tail
//   pop               - drop the head entry (caller guarantees count != 0)
//   pop_data          - head entry
//   count             - current occupancy, 0..DEPTH
module array_rsp_fifo #(
  parameter  int DEPTH  = 2,
  parameter  int DATA_W = 20,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] buf_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) buf_mem[wr_ptr] <= push_data;
  end

  assign pop_data = buf_mem[rd_ptr];
  assign count    = cnt;

endmodule

// File: rtl/array_rw_arbiter.sv
// array_rw_arbiter
//   Front end for one single-port masked SRAM macro (1-cycle registered read).
//   Arbitrates independent write and read request channels onto the macro's
//   RW0 port (round-robin on a tie), and catches read data in a response FIFO
//   so the consumer can backpressure. Reads are only issued while a FIFO slot
//   is guaranteed, so no response is ever dropped.
// Ports:
//   clock, reset                         - single clock (also RW0_clk), sync active-high reset
//   w_valid/w_ready/w_addr/w_mask/w_data - write request channel
//   r_valid/r_ready/r_addr               - read request channel
//   rsp_valid/rsp_ready/rsp_data         - read response channel
//   mem_addr/en/wmode/wmask/wdata        - to RW0_addr/en/wmode/wmask/wdata
//   mem_rdata                            - from RW0_rdata
//   init_busy                            - zeroing sweep in progress
// Build option:
//   ARRAY_RW_ARBITER_INIT_EN - when defined, every reset is followed by a sweep
//   writing zero to all 2^ADDR_W words; both request channels are held off
//   until it completes. When undefined, init_busy is tied 0.
module array_rw_arbiter
  import array_rw_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ARR_ADDR_W,
  parameter int DATA_W    = ARR_DATA_W,
  parameter int MASK_SEG  = ARR_MASK_SEG,
  parameter int RSP_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [MASK_SEG-1:0] w_mask,
  input  logic [DATA_W-1:0]   w_data,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_en,
  output logic                mem_wmode,
  output logic [MASK_SEG-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                init_busy
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  state_t            state;
  grant_t            grant;
  grant_t            last_grant;
  logic [ADDR_W-1:0] init_addr;
  logic              vld_p1;
  logic [CNT_W-1:0]  rsp_count;
  logic [CNT_W:0]    credits_used;
  logic              run;
  logic              wr_elig;
  logic              rd_elig;
  logic              rsp_pop;

`ifdef ARRAY_RW_ARBITER_INIT_EN
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_addr_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_INIT;
      init_addr <= '0;
    end else begin
      state     <= state_nxt;
      init_addr <= init_addr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    init_addr_nxt = init_addr;
    if (state == ST_INIT) begin
      init_addr_nxt = init_addr + 1'b1;
      if (&init_addr) state_nxt = ST_RUN;
    end
  end
`else
  assign state     = ST_RUN;
  assign init_addr = '0;
`endif

  assign init_busy = (state == ST_INIT);
  assign run       = (state == ST_RUN);

  // A read is only issued if a FIFO slot is already guaranteed for it,
  // counting both stored responses and the one still inside the macro.
  assign credits_used = {1'b0, rsp_count} + (CNT_W + 1)'(vld_p1);
  assign wr_elig      = run && w_valid;
  assign rd_elig      = run && r_valid && (credits_used < (CNT_W + 1)'(RSP_DEPTH));

  always_comb begin
    grant = GNT_NONE;
    if (wr_elig && rd_elig) begin
      grant = (last_grant == GNT_WR) ? GNT_RD : GNT_WR;
    end else if (wr_elig) begin
      grant = GNT_WR;
    end else if (rd_elig) begin
      grant = GNT_RD;
    end
  end

  assign w_ready = (grant == GNT_WR);
  assign r_ready = (grant == GNT_RD);

  // Stage p0: macro port driven combinationally from the grant
  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (state == ST_INIT) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = init_addr;
      mem_wmask = '1;
    end else if (grant == GNT_WR) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = w_addr;
      mem_wmask = w_mask;
      mem_wdata = w_data;
    end else if (grant == GNT_RD) begin
      mem_en    = 1'b1;
      mem_addr  = r_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= GNT_RD;
      vld_p1     <= 1'b0;
    end else begin
      if (grant != GNT_NONE) last_grant <= grant;
      vld_p1 <= (grant == GNT_RD);
    end
  end

  // Stage p1: macro read data valid; captured into the FIFO at end of cycle
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_valid = (rsp_count != '0);

  array_rsp_fifo #(
    .DEPTH  (RSP_DEPTH),
    .DATA_W (DATA_W)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (vld_p1),
    .push_data (mem_rdata),
    .pop       (rsp_pop),
    .pop_data  (rsp_data),
    .count     (rsp_count)
  );

endmodule

// File: tb/tb_array_rw_arbiter.sv
// tb_array_rw_arbiter
//   Bench for array_rw_arbiter with a behavioural model of the masked SRAM
//   macro attached to the RW0 pins. A shadow copy of memory, updated on write
//   handshakes, supplies expected read data to a response queue.
module tb_array_rw_arbiter;

`ifdef ARRAY_RW_ARBITER_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        w_valid;
  logic        w_ready;
  logic [11:0] w_addr;
  logic [3:0]  w_mask;
  logic [19:0] w_data;
  logic        r_valid;
  logic        r_ready;
  logic [11:0] r_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [19:0] rsp_data;
  logic [11:0] mem_addr;
  logic        mem_en;
  logic        mem_wmode;
  logic [3:0]  mem_wmask;
  logic [19:0] mem_wdata;
  logic [19:0] mem_rdata;
  logic        init_busy;

  array_rw_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_addr    (w_addr),
    .w_mask    (w_mask),
    .w_data    (w_data),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_addr    (r_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mem_addr  (mem_addr),
    .mem_en    (mem_en),
    .mem_wmode (mem_wmode),
    .mem_wmask (mem_wmask),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .init_busy (init_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Contents of a never-written word in the macro model
  function automatic logic [19:0] pat(input logic [11:0] a);
    logic [31:0] t;
    t = ({20'd0, a} * 32'h9E37) ^ 32'h5A3C1;
    return t[19:0];
  endfunction

  function automatic logic [19:0] merge(input logic [19:0] old, input logic [19:0] d,
                                        input logic [3:0] m);
    logic [19:0] r;
    r = old;
    for (int s = 0; s < 4; s++) if (m[s]) r[s*5 +: 5] = d[s*5 +: 5];
    return r;
  endfunction

  // ---------------- macro model: masked write, 1-cycle registered read
  logic [19:0] mem [4096];
  bit          mem_wr [4096];

  initial mem_rdata = '0;
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wmode) begin
        mem[mem_addr]    <= merge(mem_wr[mem_addr] ? mem[mem_addr] : pat(mem_addr),
                                  mem_wdata, mem_wmask);
        mem_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : pat(mem_addr);
      end
    end
  end

  // ---------------- shadow memory and scoreboard
  logic [19:0] ref_mem [4096];
  bit          ref_wr [4096];
  logic [19:0] exp_q [$];
  logic [19:0] exp_v;
  logic        prev_hold = 1'b0;
  logic [19:0] prev_data = '0;

  function automatic logic [19:0] ref_read(input logic [11:0] a);
    if (ref_wr[a]) return ref_mem[a];
    return INIT_EN ? 20'h0 : pat(a);
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      if (INIT_EN) for (int i = 0; i < 4096; i++) ref_wr[i] = 1'b0;
      prev_hold = 1'b0;
    end else begin
      check("one_grant", {w_ready, r_ready} == 2'b11, 0);
      if (prev_hold) begin
        check("rsp_hold_valid", rsp_valid, 1);
        check("rsp_hold_data", rsp_data, prev_data);
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: got 0x%0h expected no response", rsp_data);
        end else begin
          exp_v = exp_q.pop_front();
          check("rsp_data", rsp_data, exp_v);
        end
      end
      if (w_valid && w_ready) begin
        ref_mem[w_addr] = merge(ref_read(w_addr), w_data, w_mask);
        ref_wr[w_addr]  = 1'b1;
      end
      if (r_valid && r_ready) exp_q.push_back(ref_read(r_addr));
      prev_hold = rsp_valid && !rsp_ready;
      prev_data = rsp_data;
    end
  end

  // ---------------- vector table
  typedef struct {
    logic        wv;
    logic        rv;
    logic [11:0] wa;
    logic [3:0]  wm;
    logic [19:0] wd;
    logic [11:0] ra;
    logic        ew;
    logic        er;
  } vec_t;

  vec_t vec [11];

  function automatic vec_t mk(input logic wv, input logic rv, input logic [11:0] wa,
                              input logic [3:0] wm, input logic [19:0] wd,
                              input logic [11:0] ra, input logic ew, input logic er);
    vec_t v;
    v.wv = wv; v.rv = rv; v.wa = wa; v.wm = wm; v.wd = wd; v.ra = ra; v.ew = ew; v.er = er;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    w_valid = 1'b0; r_valid = 1'b0;
    w_addr = '0; w_mask = '0; w_data = '0; r_addr = '0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || rsp_valid) && t < 40) begin
      next_cycle();
      t++;
    end
    check("drain_timeout", t < 40, 1);
  endtask

  // Called at the negedge of the first cycle after reset release
  task automatic wait_init();
    int n;
    n = 0;
    while (init_busy && n < 5000) begin
      n++;
      @(negedge clock);
    end
    check("init_cycles", n, INIT_EN ? 4096 : 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] act;
    logic [63:0] exp;
    int          acc;
    int          rsp0;
    int          stale;

    vec[0]  = mk(0, 0, 12'h000, 4'h0, 20'h00000, 12'h000, 0, 0);
    vec[1]  = mk(1, 0, 12'h010, 4'hF, 20'h12345, 12'h000, 1, 0);
    vec[2]  = mk(1, 1, 12'h040, 4'hF, 20'h11111, 12'h010, 0, 1);
    vec[3]  = mk(1, 1, 12'h020, 4'hF, 20'hFFFFF, 12'h010, 1, 0);
    vec[4]  = mk(1, 1, 12'h050, 4'hF, 20'h22222, 12'h020, 0, 1);
    vec[5]  = mk(1, 0, 12'h020, 4'h5, 20'h00000, 12'h000, 1, 0);
    vec[6]  = mk(0, 1, 12'h000, 4'h0, 20'h00000, 12'h020, 0, 1);
    vec[7]  = mk(1, 0, 12'h030, 4'h0, 20'hABCDE, 12'h000, 1, 0);
    vec[8]  = mk(0, 1, 12'h000, 4'h0, 20'h00000, 12'h030, 0, 1);
    vec[9]  = mk(1, 1, 12'h060, 4'hF, 20'h33333, 12'h010, 1, 0);
    vec[10] = mk(0, 0, 12'h000, 4'h0, 20'h00000, 12'h000, 0, 0);

    reset = 1'b1;
    rsp_ready = 1'b1;
    idle();
    repeat (3) next_cycle();
    @(negedge clock);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_init_busy", init_busy, INIT_EN);
    check("reset_no_ready", {w_ready, r_ready}, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    wait_init();

    // Table: arbitration and macro drive, rsp_ready held high
    foreach (vec[i]) begin
      next_cycle();
      w_valid = vec[i].wv; r_valid = vec[i].rv;
      w_addr = vec[i].wa; w_mask = vec[i].wm; w_data = vec[i].wd; r_addr = vec[i].ra;
      @(negedge clock);
      act = {24'd0, w_ready, r_ready, mem_en, mem_wmode, mem_addr, mem_wmask, mem_wdata};
      if (vec[i].ew)
        exp = {24'd0, 1'b1, 1'b0, 1'b1, 1'b1, vec[i].wa, vec[i].wm, vec[i].wd};
      else if (vec[i].er)
        exp = {24'd0, 1'b0, 1'b1, 1'b1, 1'b0, vec[i].ra, 4'h0, 20'h0};
      else
        exp = 64'd0;
      check($sformatf("vec%0d", i), act, exp);
    end
    next_cycle();
    idle();
    drain();

    // Minimum read latency: rsp_valid exactly two cycles after acceptance
    next_cycle();
    r_valid = 1'b1; r_addr = 12'h010;
    @(negedge clock);
    check("lat_accept", {r_ready, rsp_valid}, 2'b10);
    next_cycle();
    idle();
    @(negedge clock);
    check("lat_n1", rsp_valid, 0);
    next_cycle();
    @(negedge clock);
    check("lat_n2", rsp_valid, 1);
    check("lat_data", rsp_data, 20'h12345);
    drain();

    // Both channels valid for 8 cycles: W,R,W,R,... starting with W
    rsp0 = n_rsp;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      w_valid = 1'b1; w_addr = 12'h100 + 12'(k); w_mask = 4'hF;
      w_data = 20'h01111 * 20'(k) + 20'h1;
      r_valid = 1'b1; r_addr = (k == 0) ? 12'h100 : 12'h100 + 12'(k - 1);
      @(negedge clock);
      check($sformatf("alt%0d", k), {w_ready, r_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    next_cycle();
    idle();
    drain();
    check("alt_rsp_count", n_rsp - rsp0, 4);

    // Backpressure: only two reads fit, then reads resume once drained
    rsp_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 6; j++) begin
      next_cycle();
      r_valid = 1'b1; r_addr = 12'h100 + 12'(acc);
      @(negedge clock);
      if (r_ready) acc++;
    end
    check("bp_accepted", acc, 2);
    check("bp_stall", r_ready, 0);
    rsp_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      next_cycle();
      r_valid = 1'b1; r_addr = 12'h100 + 12'(acc);
      @(negedge clock);
      if (r_ready) acc++;
    end
    check("bp_resume", acc > 2, 1);
    next_cycle();
    idle();
    drain();

    // Top address: write then read in the next cycle
    next_cycle();
    w_valid = 1'b1; w_addr = 12'hFFF; w_mask = 4'hF; w_data = 20'h5A5A5;
    @(negedge clock);
    check("fff_wr", {w_ready, mem_wmode, mem_addr}, {1'b1, 1'b1, 12'hFFF});
    next_cycle();
    idle();
    r_valid = 1'b1; r_addr = 12'hFFF;
    @(negedge clock);
    check("fff_rd", {r_ready, mem_wmode, mem_addr}, {1'b1, 1'b0, 12'hFFF});
    next_cycle();
    idle();
    drain();

    // Reset with one FIFO entry and one read in flight
    rsp_ready = 1'b0;
    next_cycle();
    r_valid = 1'b1; r_addr = 12'h010;
    @(negedge clock);
    check("rst_rd_a", r_ready, 1);
    next_cycle();
    r_addr = 12'h020;
    @(negedge clock);
    check("rst_rd_b", r_ready, 1);
    next_cycle();
    idle();
    reset = 1'b1;
    @(negedge clock);
    check("rst_fifo_entry", rsp_valid, 1);
    next_cycle();
    reset = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    check("rst_rsp_valid", rsp_valid, 0);
    wait_init();
    stale = 0;
    for (int j = 0; j < 6; j++) begin
      next_cycle();
      @(negedge clock);
      if (rsp_valid) stale++;
    end
    check("rst_no_stale", stale, 0);
    next_cycle();
    r_valid = 1'b1; r_addr = 12'h010;
    @(negedge clock);
    check("post_rst_rd", r_ready, 1);
    next_cycle();
    idle();
    drain();
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/array_rw_arbiter.md
Name: array_rw_arbiter

Overview:
- Front-end controller for one single-port masked SRAM macro: 4096 x 20, 4 write-mask segments of 5 bits, 1-cycle registered read.
- Takes independent write and read request channels (valid/ready) and arbitrates them onto the macro's single RW port.
- Captures read data into a small response FIFO so the consumer can backpressure; the macro itself has no stall.
- Sits directly upstream of the macro and drives its RW0_* pins one-to-one.

Parameters:
- ADDR_W, 12, address width; depth = 2^ADDR_W.
- DATA_W, 20, data width.
- MASK_SEG, 4, mask segments; DATA_W/MASK_SEG bits per segment.
- RSP_DEPTH, 2, response FIFO entries; range 2..8.

Ports:
- clock  in  1  single clock; also drives macro RW0_clk.
- reset  in  1  synchronous, active-high.
- w_valid  in  1  write request valid.
- w_ready  out  1  write accepted this cycle.
- w_addr  in  ADDR_W  write address.
- w_mask  in  MASK_SEG  per-segment write enable.
- w_data  in  DATA_W  write data.
- r_valid  in  1  read request valid.
- r_ready  out  1  read accepted this cycle.
- r_addr  in  ADDR_W  read address.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_W  read response data.
- mem_addr  out  ADDR_W  to RW0_addr.
- mem_en  out  1  to RW0_en.
- mem_wmode  out  1  to RW0_wmode.
- mem_wmask  out  MASK_SEG  to RW0_wmask.
- mem_wdata  out  DATA_W  to RW0_wdata.
- mem_rdata  in  DATA_W  from RW0_rdata.
- init_busy  out  1  initialisation sweep in progress; constant 0 when the optional feature is compiled out.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: rsp_valid=0, FIFO count=0, inflight=0, last_grant=read (so write wins the first tie), init_busy=1 if INIT enabled, else 0.
- Macro drive is combinational from the grant; only one of w_ready and r_ready is high in a cycle.
  - Write grant: mem_en=1, mem_wmode=1, mem_addr=w_addr, mem_wmask=w_mask, mem_wdata=w_data.
  - Read grant: mem_en=1, mem_wmode=0, mem_addr=r_addr, mem_wmask=0, mem_wdata=0.
  - No grant: mem_en=0, all other mem_* outputs 0.
- Read eligibility: read may be granted only if (FIFO count + inflight) < RSP_DEPTH. This credit rule guarantees no response is ever dropped.
- Arbitration:
  - Only one channel eligible: grant it.
  - Both eligible: grant the channel not granted last time (round-robin on last_grant).
  - last_grant updates only when a grant occurs.
- Read latency:
  - Read accepted in cycle N; inflight=1 during cycle N+1.
  - mem_rdata is pushed into the FIFO at the end of N+1.
  - rsp_valid is asserted from N+2 onward; minimum latency is 2 cycles.
- FIFO:
  - Circular buffer; pointers wrap modulo RSP_DEPTH.
  - Push and pop in the same cycle: count unchanged.
  - rsp_data = head entry; held stable while rsp_valid && !rsp_ready.
- Ordering: responses return strictly in request order. Write-then-read to the same address in consecutive cycles returns the new data, because the macro writes at the end of the write cycle.
- Mask of zero: write still consumes the port cycle; memory is unchanged.
- Reset mid-operation: the in-flight read and all FIFO contents are discarded; rsp_valid drops the next cycle. Memory contents are not touched unless INIT is enabled.

Optional Feature:
- Macro: ARRAY_RW_ARBITER_INIT_EN.
- Defined:
  - After reset, an INIT state sweeps addresses 0..2^ADDR_W-1, one per cycle: mem_en=1, wmode=1, wmask=all ones, wdata=0.
  - init_busy=1 and w_ready=r_ready=0 throughout; the sweep takes 2^ADDR_W cycles (4096 by default).
  - Then the block transitions to RUN. Reset during INIT restarts the sweep at 0.
- Undefined: the block enters RUN directly; init_busy is tied 0; memory contents after reset are undefined.

Decomposition:
- Shared package holds: ADDR_W/DATA_W/MASK_SEG constants, SEG_W = DATA_W/MASK_SEG, the state enum (INIT, RUN), and the grant enum (NONE, WR, RD).
- One sub-module: array_rsp_fifo, a parameterised RSP_DEPTH x DATA_W circular FIFO exposing its count.
- Arbiter, credit check and INIT counter stay in the top module.

Test Plan:
- Write 0x12345 to addr 0x010 with mask 4'b1111, then read addr 0x010 -> rsp_data=0x12345 with rsp_valid exactly 2 cycles after r_ready.
- Write 0xFFFFF to addr 0x020 (full mask), then 0x00000 with mask 4'b0101, then read -> rsp_data=0xF83E0.
- w_valid and r_valid held high for 8 cycles, rsp_ready=1 -> grants alternate W,R,W,R,... starting with W; 4 responses returned in order.
- rsp_ready=0 with reads issued back-to-back -> exactly 2 reads accepted, then r_ready=0. Raise rsp_ready -> both responses in order, then reads resume.
- Write to addr 0xFFF followed by read of addr 0xFFF in the next cycle -> new data returned (boundary address, no wrap error).
- Assert reset with one read in flight and 1 FIFO entry -> rsp_valid=0 the cycle after reset; no stale response afterwards. With INIT_EN: init_busy stays high for 4096 cycles, then a read of any address returns 0.
